// File: rtl/mux16_scan_serializer.sv
// mux16_scan_serializer
// Captures a 16-bit word, walks the external 16:1 mux select across all
// positions, samples mux_y after a programmable settle time and streams the
// sampled bits out one at a time. Reports a done pulse and a ones count.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both 1. load_ready depends only on the FSM state (never on load_valid).
// Once bit_valid is raised, bit_valid/bit_data/bit_index stay stable until
// the edge where bit_ready is 1; bit_valid never drops without a transfer
// (reset excepted).
module mux16_scan_serializer #(
    parameter bit MSB_FIRST   = 1'b0,
    parameter int HOLD_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_valid,
    input  logic [15:0] load_data,
    output logic        load_ready,
    output logic [15:0] mux_d,
    output logic [3:0]  mux_sel,
    input  logic        mux_y,
    output logic        bit_valid,
    output logic        bit_data,
    output logic [3:0]  bit_index,
    input  logic        bit_ready,
    output logic        busy,
    output logic        done,
    output logic [4:0]  ones_count
);

    generate
        if (HOLD_CYCLES < 1 || HOLD_CYCLES > 15) begin : g_bad_hold
            $error("mux16_scan_serializer: HOLD_CYCLES must be in 1..15");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        OUT    = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [3:0] FIRST_SEL = MSB_FIRST ? 4'd15 : 4'd0;
    localparam logic [3:0] LAST_SEL  = MSB_FIRST ? 4'd0  : 4'd15;
    localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

    state_t     state_q;
    state_t     state_d;
    logic [3:0] hold_cnt;

    logic load_fire;
    logic sample_now;
    logic deliver;
    logic last_bit;

    assign load_fire  = (state_q == IDLE) && load_valid;
    assign sample_now = (state_q == SETTLE) && (hold_cnt == HOLD_LAST);
    assign deliver    = (state_q == OUT) && bit_ready;
    assign last_bit   = (bit_index == LAST_SEL);

    assign load_ready = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);

    // Next-state decode for the scan sequence.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (load_valid) state_d = SETTLE;
            SETTLE:  if (sample_now) state_d = OUT;
            OUT:     if (bit_ready)  state_d = last_bit ? DONE : SETTLE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register; reset aborts any frame in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath: word capture, select stepping, bit sampling and ones count.
    always_ff @(posedge clk) begin
        if (rst) begin
            mux_d      <= 16'd0;
            mux_sel    <= 4'd0;
            hold_cnt   <= 4'd0;
            bit_valid  <= 1'b0;
            bit_data   <= 1'b0;
            bit_index  <= 4'd0;
            ones_count <= 5'd0;
        end else begin
            if (load_fire) begin
                mux_d      <= load_data;
                mux_sel    <= FIRST_SEL;
                hold_cnt   <= 4'd0;
                ones_count <= 5'd0;
            end
            if (state_q == SETTLE) begin
                if (sample_now) begin
                    bit_data  <= mux_y;
                    bit_index <= mux_sel;
                    bit_valid <= 1'b1;
                end else begin
                    hold_cnt <= hold_cnt + 4'd1;
                end
            end
            if (deliver) begin
                bit_valid  <= 1'b0;
                ones_count <= ones_count + {4'd0, bit_data};
                // The select parks on the last position; it never wraps.
                if (!last_bit) begin
                    mux_sel  <= MSB_FIRST ? (mux_sel - 4'd1) : (mux_sel + 4'd1);
                    hold_cnt <= 4'd0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mux16_scan_serializer.sv
// Testbench for mux16_scan_serializer: three instances cover LSB-first H=1,
// MSB-first H=1 and LSB-first H=3. The 16:1 mux is modelled behaviourally.
module tb_mux16_scan_serializer;

    logic clk = 1'b0;
    logic rst;

    logic [2:0]       load_valid;
    logic [2:0][15:0] load_data;
    logic [2:0]       load_ready;
    logic [2:0][15:0] mux_d;
    logic [2:0][3:0]  mux_sel;
    logic [2:0]       mux_y;
    logic [2:0]       bit_valid;
    logic [2:0]       bit_data;
    logic [2:0][3:0]  bit_index;
    logic [2:0]       bit_ready;
    logic [2:0]       busy;
    logic [2:0]       done;
    logic [2:0][4:0]  ones_count;

    int n_vec = 0;
    int n_err = 0;

    // clock / reset block
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mux16_scan_serializer #(
            .MSB_FIRST  (g == 1),
            .HOLD_CYCLES((g == 2) ? 3 : 1)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .load_valid(load_valid[g]),
            .load_data (load_data[g]),
            .load_ready(load_ready[g]),
            .mux_d     (mux_d[g]),
            .mux_sel   (mux_sel[g]),
            .mux_y     (mux_y[g]),
            .bit_valid (bit_valid[g]),
            .bit_data  (bit_data[g]),
            .bit_index (bit_index[g]),
            .bit_ready (bit_ready[g]),
            .busy      (busy[g]),
            .done      (done[g]),
            .ones_count(ones_count[g])
        );
        assign mux_y[g] = mux_d[g][mux_sel[g]];
    end

    // Runs one frame on instance u and checks it against the reference model:
    // bit k of the stream is word[k] (LSB-first) or word[15-k] (MSB-first).
    task automatic run_frame(input int u, input logic [15:0] word, input int h, input bit msb,
                             input logic [15:0] stall_mask, input int stall_len, input bit chk_time,
                             input string tag);
        logic [4:0] exp_q[$];
        logic [4:0] exp_e;
        int e, k, idx, exp_ones;
        bit fin;
        exp_ones = 0;
        for (int i = 0; i < 16; i++) begin
            idx = msb ? 15 - i : i;
            exp_q.push_back({4'(idx), word[idx]});
            exp_ones = exp_ones + int'(word[idx]);
        end
        @(negedge clk);
        n_vec++; if (load_ready[u] !== 1'b1) begin n_err++; $display("FAIL %s load_ready_before: got %0b expected 1", tag, load_ready[u]); end
        load_valid[u] = 1'b1;
        load_data[u]  = word;
        bit_ready[u]  = 1'b1;
        @(posedge clk); #1;
        load_valid[u] = 1'b0;
        e = 0; k = 0; fin = 1'b0;
        n_vec++; if (mux_d[u] !== word) begin n_err++; $display("FAIL %s mux_d_load: got %0h expected %0h", tag, mux_d[u], word); end
        n_vec++; if (mux_sel[u] !== (msb ? 4'd15 : 4'd0)) begin n_err++; $display("FAIL %s mux_sel_start: got %0d expected %0d", tag, mux_sel[u], msb ? 15 : 0); end
        n_vec++; if (busy[u] !== 1'b1 || load_ready[u] !== 1'b0) begin n_err++; $display("FAIL %s busy_after_load: got busy=%0b ready=%0b expected 1/0", tag, busy[u], load_ready[u]); end
        while (!fin && e < 400) begin
            @(posedge clk); #1; e++;
            n_vec++; if (mux_d[u] !== word) begin n_err++; $display("FAIL %s mux_d_hold: got %0h expected %0h", tag, mux_d[u], word); end
            if (done[u]) begin
                fin = 1'b1;
                if (chk_time) begin
                    n_vec++; if (e != 16 * (h + 1)) begin n_err++; $display("FAIL %s done_time: got edge %0d expected %0d", tag, e, 16 * (h + 1)); end
                end
                n_vec++; if (ones_count[u] !== 5'(exp_ones)) begin n_err++; $display("FAIL %s ones_count: got %0d expected %0d", tag, ones_count[u], exp_ones); end
                n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL %s bits_missing: got %0d left expected 0", tag, exp_q.size()); end
                n_vec++; if (bit_valid[u] !== 1'b0 || load_ready[u] !== 1'b0 || busy[u] !== 1'b1) begin n_err++; $display("FAIL %s done_cycle: got valid=%0b ready=%0b busy=%0b expected 0/0/1", tag, bit_valid[u], load_ready[u], busy[u]); end
            end else if (bit_valid[u]) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++; $display("FAIL %s extra_bit: got index %0d expected none", tag, bit_index[u]);
                end else begin
                    exp_e = exp_q.pop_front();
                    if (bit_index[u] !== exp_e[4:1] || bit_data[u] !== exp_e[0] || mux_sel[u] !== exp_e[4:1]) begin
                        n_err++; $display("FAIL %s bit%0d: got idx=%0d data=%0b sel=%0d expected idx=%0d data=%0b", tag, k, bit_index[u], bit_data[u], mux_sel[u], exp_e[4:1], exp_e[0]);
                    end
                    if (chk_time) begin
                        n_vec++; if (e != k * (h + 1) + h) begin n_err++; $display("FAIL %s bit%0d_time: got edge %0d expected %0d", tag, k, e, k * (h + 1) + h); end
                    end
                    if (stall_mask[k]) begin
                        bit_ready[u] = 1'b0;
                        repeat (stall_len) begin
                            @(posedge clk); #1; e++;
                            n_vec++;
                            if (bit_valid[u] !== 1'b1 || bit_index[u] !== exp_e[4:1] || bit_data[u] !== exp_e[0] || mux_sel[u] !== exp_e[4:1] || done[u] !== 1'b0) begin
                                n_err++; $display("FAIL %s stall_bit%0d: got v=%0b idx=%0d data=%0b sel=%0d expected v=1 idx=%0d data=%0b", tag, k, bit_valid[u], bit_index[u], bit_data[u], mux_sel[u], exp_e[4:1], exp_e[0]);
                            end
                        end
                        bit_ready[u] = 1'b1;
                    end
                    k++;
                end
            end
        end
        if (!fin) begin
            n_vec++; n_err++; $display("FAIL %s timeout: got no done after %0d edges expected done", tag, e);
        end
        @(posedge clk); #1;
        n_vec++; if (load_ready[u] !== 1'b1 || busy[u] !== 1'b0 || done[u] !== 1'b0) begin n_err++; $display("FAIL %s after_done: got ready=%0b busy=%0b done=%0b expected 1/0/0", tag, load_ready[u], busy[u], done[u]); end
        n_vec++; if (ones_count[u] !== 5'(exp_ones)) begin n_err++; $display("FAIL %s ones_hold: got %0d expected %0d", tag, ones_count[u], exp_ones); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        load_valid = '0; load_data = '0; bit_ready = '1;
        repeat (3) @(posedge clk);
        #1;
        for (int u = 0; u < 3; u++) begin
            n_vec++;
            if (load_ready[u] !== 1'b1 || busy[u] !== 1'b0 || mux_sel[u] !== 4'd0 || mux_d[u] !== 16'd0 ||
                bit_valid[u] !== 1'b0 || bit_data[u] !== 1'b0 || bit_index[u] !== 4'd0 || done[u] !== 1'b0 || ones_count[u] !== 5'd0) begin
                n_err++; $display("FAIL reset_state u%0d: got ready=%0b busy=%0b sel=%0d d=%0h v=%0b idx=%0d done=%0b ones=%0d expected 1/0/0/0/0/0/0/0", u, load_ready[u], busy[u], mux_sel[u], mux_d[u], bit_valid[u], bit_index[u], done[u], ones_count[u]);
            end
        end
        @(negedge clk); rst = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            for (int u = 0; u < 3; u++) begin
                n_vec++;
                if (load_ready[u] !== 1'b1 || busy[u] !== 1'b0 || bit_valid[u] !== 1'b0 || done[u] !== 1'b0) begin
                    n_err++; $display("FAIL idle_quiet u%0d: got ready=%0b busy=%0b v=%0b done=%0b expected 1/0/0/0", u, load_ready[u], busy[u], bit_valid[u], done[u]);
                end
            end
        end
    endtask

    task automatic test_lsb_first();
        run_frame(0, 16'hACF1, 1, 1'b0, 16'h0000, 0, 1'b1, "lsb_acf1");
    endtask

    task automatic test_msb_first();
        run_frame(1, 16'hA55A, 1, 1'b1, 16'h0000, 0, 1'b1, "msb_a55a");
    endtask

    task automatic test_backpressure();
        run_frame(0, 16'hA55A, 1, 1'b0, 16'h0208, 5, 1'b0, "bp_lsb");
        run_frame(1, 16'hA55A, 1, 1'b1, 16'h0208, 5, 1'b0, "bp_msb");
    endtask

    task automatic test_hold3();
        run_frame(2, 16'h8000, 3, 1'b0, 16'h0000, 0, 1'b1, "h3_8000");
    endtask

    task automatic test_random();
        int u;
        logic [15:0] w, m;
        for (int i = 0; i < 8; i++) begin
            u = $urandom_range(0, 2);
            w = 16'($urandom);
            m = 16'($urandom);
            if (i < 3) m = 16'h0000;
            run_frame(u, w, (u == 2) ? 3 : 1, (u == 1), m, $urandom_range(1, 4), (m == 16'h0000), "random");
        end
    endtask

    task automatic test_busy_and_reset();
        logic [15:0] word;
        int e;
        bit hit;
        word = 16'h5A3C;
        @(negedge clk);
        load_valid[0] = 1'b1; load_data[0] = word; bit_ready[0] = 1'b1;
        @(posedge clk); #1;
        load_data[0] = 16'hFFFF;
        e = 0; hit = 1'b0;
        while (!hit && e < 100) begin
            @(posedge clk); #1; e++;
            n_vec++; if (mux_d[0] !== word || load_ready[0] !== 1'b0) begin n_err++; $display("FAIL busy_ignore: got d=%0h ready=%0b expected %0h/0", mux_d[0], load_ready[0], word); end
            if (bit_valid[0] && bit_index[0] == 4'd7) begin
                hit = 1'b1;
                bit_ready[0] = 1'b0;
            end
        end
        n_vec++; if (!hit) begin n_err++; $display("FAIL midreset_reach: got no bit 7 expected bit 7"); end
        n_vec++; if (ones_count[0] !== 5'($countones(word[6:0]))) begin n_err++; $display("FAIL midreset_partial_ones: got %0d expected %0d", ones_count[0], $countones(word[6:0])); end
        rst = 1'b1; load_valid[0] = 1'b0;
        @(posedge clk); #1;
        n_vec++;
        if (load_ready[0] !== 1'b1 || busy[0] !== 1'b0 || mux_sel[0] !== 4'd0 || mux_d[0] !== 16'd0 ||
            bit_valid[0] !== 1'b0 || bit_data[0] !== 1'b0 || bit_index[0] !== 4'd0 || done[0] !== 1'b0 || ones_count[0] !== 5'd0) begin
            n_err++; $display("FAIL midreset_state: got ready=%0b busy=%0b sel=%0d d=%0h v=%0b idx=%0d done=%0b ones=%0d expected reset values", load_ready[0], busy[0], mux_sel[0], mux_d[0], bit_valid[0], bit_index[0], done[0], ones_count[0]);
        end
        rst = 1'b0; bit_ready[0] = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            n_vec++; if (done[0] !== 1'b0 || bit_valid[0] !== 1'b0) begin n_err++; $display("FAIL midreset_no_done: got done=%0b v=%0b expected 0/0", done[0], bit_valid[0]); end
        end
        run_frame(0, 16'h0001, 1, 1'b0, 16'h0000, 0, 1'b1, "after_reset_0001");
    endtask

    task automatic test_back_to_back();
        run_frame(1, 16'hFFFF, 1, 1'b1, 16'h0000, 0, 1'b1, "b2b_ffff");
        run_frame(1, 16'h0000, 1, 1'b1, 16'h0000, 0, 1'b1, "b2b_0000");
    endtask

    initial begin
        test_reset();
        test_lsb_first();
        test_msb_first();
        test_backpressure();
        test_hold3();
        test_busy_and_reset();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
